// File: rtl/mips64_mem_pkg.sv
// Shared types and constants for the MIPS64 load/store unit and its lane logic.
package mips64_mem_pkg;

  localparam int unsigned MEM_DATA_BITS = 64;
  localparam int unsigned MEM_ADDR_BITS = 64;
  localparam int unsigned OFFS_BITS     = 3;
  localparam int unsigned SHIFT_BITS    = 6;
  localparam int unsigned BYTE_BITS     = 8;
  localparam int unsigned HALF_BITS     = 16;
  localparam int unsigned WORD_BITS     = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LDX  = 3'd2,
    ST_MRG  = 3'd3,
    ST_WR   = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // Request fields kept for the whole access; the word index lives in the RAM address register.
  typedef struct packed {
    logic                     is_store;
    size_e                    size;
    logic                     sign_ext;
    logic [OFFS_BITS-1:0]     offset;
    logic [MEM_DATA_BITS-1:0] wdata;
  } mem_req_t;

  function automatic logic is_misaligned(input size_e sz, input logic [OFFS_BITS-1:0] off);
    logic mis;
    mis = 1'b0;
    case (sz)
      SIZE_H:  mis = off[0];
      SIZE_W:  mis = |off[1:0];
      SIZE_D:  mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bundle of the load/store unit.
interface mem_access_unit_if;
  import mips64_mem_pkg::*;

  logic                     req;
  logic                     is_store;
  logic [1:0]               size;
  logic                     sign_ext;
  logic [MEM_ADDR_BITS-1:0] addr;
  logic [MEM_DATA_BITS-1:0] wdata;
  logic                     busy;
  logic                     done;
  logic                     misalign;
  logic [MEM_DATA_BITS-1:0] rdata;

  modport master (
    output req, is_store, size, sign_ext, addr, wdata,
    input  busy, done, misalign, rdata
  );

  modport slave (
    input  req, is_store, size, sign_ext, addr, wdata,
    output busy, done, misalign, rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Big-endian lane logic: extracts/extends load lanes and merges store lanes into a RAM word.
module mem_lane_align
  import mips64_mem_pkg::*;
(
  input  logic [MEM_DATA_BITS-1:0] i_word,
  input  logic [MEM_DATA_BITS-1:0] i_data,
  input  logic [OFFS_BITS-1:0]     i_offset,
  input  size_e                    i_size,
  input  logic                     i_sign,
  output logic [MEM_DATA_BITS-1:0] o_load_c,
  output logic [MEM_DATA_BITS-1:0] o_merge_c
);

  logic [SHIFT_BITS-1:0]    w_shift;
  logic [MEM_DATA_BITS-1:0] w_mask;
  logic [MEM_DATA_BITS-1:0] w_lane;

  // Lane k sits MSB-first, so its LSB is (last lane index - k) bytes above bit 0.
  always_comb begin
    w_shift = '0;
    w_mask  = '1;
    case (i_size)
      SIZE_B: begin
        w_shift = {3'(3'd7 - i_offset), 3'b000};
        w_mask  = {{(MEM_DATA_BITS-BYTE_BITS){1'b0}}, {BYTE_BITS{1'b1}}};
      end
      SIZE_H: begin
        w_shift = {3'(3'd6 - {i_offset[2:1], 1'b0}), 3'b000};
        w_mask  = {{(MEM_DATA_BITS-HALF_BITS){1'b0}}, {HALF_BITS{1'b1}}};
      end
      SIZE_W: begin
        w_shift = {3'(3'd4 - {i_offset[2], 2'b00}), 3'b000};
        w_mask  = {{(MEM_DATA_BITS-WORD_BITS){1'b0}}, {WORD_BITS{1'b1}}};
      end
      default: begin
        w_shift = '0;
        w_mask  = '1;
      end
    endcase
  end

  assign w_lane = i_word >> w_shift;

  always_comb begin
    o_load_c = w_lane;
    case (i_size)
      SIZE_B:  o_load_c = {{(MEM_DATA_BITS-BYTE_BITS){i_sign & w_lane[BYTE_BITS-1]}},
                           w_lane[BYTE_BITS-1:0]};
      SIZE_H:  o_load_c = {{(MEM_DATA_BITS-HALF_BITS){i_sign & w_lane[HALF_BITS-1]}},
                           w_lane[HALF_BITS-1:0]};
      SIZE_W:  o_load_c = {{(MEM_DATA_BITS-WORD_BITS){i_sign & w_lane[WORD_BITS-1]}},
                           w_lane[WORD_BITS-1:0]};
      default: o_load_c = w_lane;
    endcase
  end

  assign o_merge_c = (i_word & ~(w_mask << w_shift)) | ((i_data & w_mask) << w_shift);

endmodule

// File: rtl/mem_access_unit.sv
// MIPS64 load/store unit: byte-addressed accesses onto a word-wide RAM without byte enables.
module mem_access_unit
  import mips64_mem_pkg::*;
#(
  parameter int unsigned DATA_BITS = MEM_DATA_BITS,
  parameter int unsigned ADDR_BITS = MEM_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_access_unit_if.slave     io_pipe,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [DATA_BITS-1:0] o_mem_d_in,
  output logic                 o_mem_en,
  output logic                 o_mem_wr,
  input  logic [DATA_BITS-1:0] i_mem_d_out
);

  state_e                r_state;
  state_e                w_next;
  mem_req_t              r_req;
  mem_req_t              w_req;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_done;
  logic                  r_misalign;
  logic                  w_misalign;
  logic [DATA_BITS-1:0]  r_rdata;
  logic [DATA_BITS-1:0]  w_rdata;
  logic [ADDR_BITS-1:0]  r_mem_addr;
  logic [ADDR_BITS-1:0]  w_mem_addr;
  logic [DATA_BITS-1:0]  r_mem_d_in;
  logic [DATA_BITS-1:0]  w_mem_d_in;
  logic                  r_mem_en;
  logic                  w_mem_en;
  logic                  r_mem_wr;
  logic                  w_mem_wr;
  size_e                 w_size;
  logic [DATA_BITS-1:0]  w_load_c;
  logic [DATA_BITS-1:0]  w_merge_c;

  assign w_size = size_e'(io_pipe.size);

  mem_lane_align u_lane (
    .i_word    (i_mem_d_out),
    .i_data    (r_req.wdata),
    .i_offset  (r_req.offset),
    .i_size    (r_req.size),
    .i_sign    (r_req.sign_ext),
    .o_load_c  (w_load_c),
    .o_merge_c (w_merge_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_req      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_rdata    <= '0;
      r_mem_addr <= '0;
      r_mem_d_in <= '0;
      r_mem_en   <= 1'b0;
      r_mem_wr   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_req      <= w_req;
      r_busy     <= (w_next != ST_IDLE);
      r_done     <= w_done;
      r_misalign <= w_misalign;
      r_rdata    <= w_rdata;
      r_mem_addr <= w_mem_addr;
      r_mem_d_in <= w_mem_d_in;
      r_mem_en   <= w_mem_en;
      r_mem_wr   <= w_mem_wr;
    end
  end

  // Misaligned accesses complete from ERR itself so done follows the request by one cycle.
  always_comb begin
    w_next     = r_state;
    w_req      = r_req;
    w_done     = 1'b0;
    w_misalign = 1'b0;
    w_rdata    = r_rdata;
    w_mem_addr = r_mem_addr;
    w_mem_d_in = r_mem_d_in;
    w_mem_en   = 1'b0;
    w_mem_wr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_pipe.req) begin
          w_req = '{is_store: io_pipe.is_store,
                    size:     w_size,
                    sign_ext: io_pipe.sign_ext,
                    offset:   io_pipe.addr[OFFS_BITS-1:0],
                    wdata:    io_pipe.wdata};
          if (is_misaligned(w_size, io_pipe.addr[OFFS_BITS-1:0])) begin
            w_next     = ST_ERR;
            w_done     = 1'b1;
            w_misalign = 1'b1;
          end else if (io_pipe.is_store && (w_size == SIZE_D)) begin
            w_next     = ST_WR;
            w_mem_addr = io_pipe.addr >> OFFS_BITS;
            w_mem_d_in = io_pipe.wdata;
            w_mem_en   = 1'b1;
            w_mem_wr   = 1'b1;
          end else begin
            w_next     = ST_RD;
            w_mem_addr = io_pipe.addr >> OFFS_BITS;
            w_mem_en   = 1'b1;
          end
        end
      end
      ST_RD: begin
        w_next = r_req.is_store ? ST_MRG : ST_LDX;
      end
      ST_LDX: begin
        w_next  = ST_IDLE;
        w_rdata = w_load_c;
        w_done  = 1'b1;
      end
      ST_MRG: begin
        w_next     = ST_WR;
        w_mem_d_in = w_merge_c;
        w_mem_en   = 1'b1;
        w_mem_wr   = 1'b1;
      end
      ST_WR: begin
        w_next = ST_IDLE;
        w_done = 1'b1;
      end
      ST_ERR: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign io_pipe.busy     = r_busy;
  assign io_pipe.done     = r_done;
  assign io_pipe.misalign = r_misalign;
  assign io_pipe.rdata    = r_rdata;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_d_in       = r_mem_d_in;
  assign o_mem_en         = r_mem_en;
  assign o_mem_wr         = r_mem_wr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit against a behavioural data_MEM model.
module tb_mem_access_unit;
  import mips64_mem_pkg::*;

  localparam int unsigned RAM_WORDS = 64;

  typedef struct {
    logic        mis;
    logic [63:0] rdata;
    int unsigned lat;
    int unsigned t0;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] mem_addr;
  logic [63:0] mem_d_in;
  logic [63:0] mem_d_out = '0;
  logic        mem_en;
  logic        mem_wr;

  logic [63:0] ram [RAM_WORDS];
  int unsigned cyc = 0;
  int unsigned n_wr = 0;
  int unsigned n_en = 0;
  int unsigned n_oob = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] model_rdata = '0;

  always #5 clk = ~clk;

  mem_access_unit_if pipe();

  mem_access_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_pipe     (pipe),
    .o_mem_addr  (mem_addr),
    .o_mem_d_in  (mem_d_in),
    .o_mem_en    (mem_en),
    .o_mem_wr    (mem_wr),
    .i_mem_d_out (mem_d_out)
  );

  // data_MEM model: synchronous write, read data valid the cycle after en & !wr
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      n_en <= n_en + 1;
      if (mem_addr[63:6] != '0) n_oob <= n_oob + 1;
      if (mem_wr) begin
        ram[mem_addr[5:0]] = mem_d_in;
        n_wr <= n_wr + 1;
      end else begin
        mem_d_out <= ram[mem_addr[5:0]];
      end
    end
  end

  // Completion monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (pipe.done) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done at cycle %0d with empty scoreboard", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          n_chk++;
          if (pipe.misalign !== mon_e.mis) begin
            n_fail++;
            $display("FAIL %s misalign=%b required %b", mon_e.name, pipe.misalign, mon_e.mis);
          end
          n_chk++;
          if (pipe.rdata !== mon_e.rdata) begin
            n_fail++;
            $display("FAIL %s rdata=%h required %h", mon_e.name, pipe.rdata, mon_e.rdata);
          end
          n_chk++;
          if ((cyc - mon_e.t0) !== mon_e.lat) begin
            n_fail++;
            $display("FAIL %s latency=%0d required %0d", mon_e.name, cyc - mon_e.t0, mon_e.lat);
          end
        end
      end else begin
        n_chk++;
        if (pipe.misalign !== 1'b0) begin
          n_fail++;
          $display("FAIL misalign_without_done misalign=%b required 0", pipe.misalign);
        end
      end
    end
  end

  task automatic issue(input string name, input logic st, input logic [1:0] sz,
                       input logic sx, input logic [63:0] a, input logic [63:0] wd,
                       input logic mis, input logic [63:0] exp_rd, input int unsigned lat,
                       input logic hold);
    exp_t        e;
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (pipe.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (pipe.busy) begin
      n_chk++; n_fail++;
      $display("FAIL %s accept_timeout busy=%b required 0", name, pipe.busy);
    end
    pipe.req      = 1'b1;
    pipe.is_store = st;
    pipe.size     = sz;
    pipe.sign_ext = sx;
    pipe.addr     = a;
    pipe.wdata    = wd;
    e.mis   = mis;
    e.rdata = exp_rd;
    e.lat   = lat;
    e.t0    = cyc;
    e.name  = name;
    exp_q.push_back(e);
    @(posedge clk);
    if (!hold) begin
      #1 pipe.req = 1'b0;
    end
  endtask

  task automatic finish_ops(input string name);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || pipe.busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    pipe.req = 1'b0;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain pending=%0d required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    pipe.req = 1'b0; pipe.is_store = 1'b0; pipe.size = 2'b00;
    pipe.sign_ext = 1'b0; pipe.addr = '0; pipe.wdata = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (pipe.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy busy=%b required 0", pipe.busy); end
    n_chk++; if (pipe.done !== 1'b0) begin n_fail++; $display("FAIL reset_done done=%b required 0", pipe.done); end
    n_chk++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en mem_en=%b required 0", mem_en); end
    n_chk++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr mem_wr=%b required 0", mem_wr); end
    n_chk++; if (pipe.rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata rdata=%h required 0", pipe.rdata); end
    n_chk++; if (mem_addr !== 64'd0) begin n_fail++; $display("FAIL reset_mem_addr mem_addr=%h required 0", mem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (pipe.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy busy=%b required 0", pipe.busy); end
    n_chk++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_mem_en mem_en=%b required 0", mem_en); end
  endtask

  task automatic test_loads();
    issue("ld_0x10", 1'b0, SIZE_D, 1'b0, 64'h10, '0, 1'b0, 64'h8899AABBCCDDEEFF, 3, 1'b0);
    issue("lb_0x13", 1'b0, SIZE_B, 1'b1, 64'h13, '0, 1'b0, 64'hFFFFFFFFFFFFFFBB, 3, 1'b0);
    issue("lbu_0x13", 1'b0, SIZE_B, 1'b0, 64'h13, '0, 1'b0, 64'h00000000000000BB, 3, 1'b0);
    issue("lh_0x14", 1'b0, SIZE_H, 1'b1, 64'h14, '0, 1'b0, 64'hFFFFFFFFFFFFCCDD, 3, 1'b0);
    issue("lhu_0x16", 1'b0, SIZE_H, 1'b0, 64'h16, '0, 1'b0, 64'h000000000000EEFF, 3, 1'b0);
    issue("lw_0x10", 1'b0, SIZE_W, 1'b1, 64'h10, '0, 1'b0, 64'hFFFFFFFF8899AABB, 3, 1'b0);
    issue("lwu_0x14", 1'b0, SIZE_W, 1'b0, 64'h14, '0, 1'b0, 64'h00000000CCDDEEFF, 3, 1'b0);
    issue("ld_signed", 1'b0, SIZE_D, 1'b1, 64'h10, '0, 1'b0, 64'h8899AABBCCDDEEFF, 3, 1'b0);
    issue("lb_0x17", 1'b0, SIZE_B, 1'b1, 64'h17, '0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3, 1'b0);
    issue("lb_0x11", 1'b0, SIZE_B, 1'b1, 64'h11, '0, 1'b0, 64'hFFFFFFFFFFFFFF99, 3, 1'b0);
    finish_ops("loads");
    model_rdata = 64'hFFFFFFFFFFFFFF99;
  endtask

  task automatic test_substores();
    issue("sh_0x1a", 1'b1, SIZE_H, 1'b0, 64'h1A, 64'h1234, 1'b0, model_rdata, 4, 1'b0);
    finish_ops("sh");
    n_chk++; if (ram[3] !== 64'h0000123400000000) begin n_fail++; $display("FAIL sh_ram3 ram=%h required %h", ram[3], 64'h0000123400000000); end
    issue("sb_0x18", 1'b1, SIZE_B, 1'b0, 64'h18, 64'hAAAAAAAAAAAAAA77, 1'b0, model_rdata, 4, 1'b0);
    finish_ops("sb");
    n_chk++; if (ram[3] !== 64'h7700123400000000) begin n_fail++; $display("FAIL sb_ram3 ram=%h required %h", ram[3], 64'h7700123400000000); end
    issue("sw_0x1c", 1'b1, SIZE_W, 1'b0, 64'h1C, 64'hDEADBEEF11223344, 1'b0, model_rdata, 4, 1'b0);
    finish_ops("sw");
    n_chk++; if (ram[3] !== 64'h7700123411223344) begin n_fail++; $display("FAIL sw_ram3 ram=%h required %h", ram[3], 64'h7700123411223344); end
  endtask

  task automatic test_abort();
    int unsigned wr0;
    wr0 = n_wr;
    issue("sb_abort", 1'b1, SIZE_B, 1'b0, 64'h08, 64'h22, 1'b0, model_rdata, 4, 1'b0);
    #1;
    n_chk++; if (pipe.busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy busy=%b required 1", pipe.busy); end
    n_chk++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL abort_pre_mem_en mem_en=%b required 1", mem_en); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (pipe.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy busy=%b required 0", pipe.busy); end
    n_chk++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL abort_mem_en mem_en=%b required 0", mem_en); end
    n_chk++; if (mem_addr !== 64'd0) begin n_fail++; $display("FAIL abort_mem_addr mem_addr=%h required 0", mem_addr); end
    n_chk++; if (mem_d_in !== 64'd0) begin n_fail++; $display("FAIL abort_mem_d_in mem_d_in=%h required 0", mem_d_in); end
    n_chk++; if (pipe.rdata !== 64'd0) begin n_fail++; $display("FAIL abort_rdata rdata=%h required 0", pipe.rdata); end
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_rdata = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (ram[1] !== 64'h1111111111111111) begin n_fail++; $display("FAIL abort_ram1 ram=%h required %h", ram[1], 64'h1111111111111111); end
    n_chk++; if (n_wr !== wr0) begin n_fail++; $display("FAIL abort_writes writes=%0d required %0d", n_wr, wr0); end
  endtask

  task automatic test_misalign();
    int unsigned en0;
    issue("ld_before_mis", 1'b0, SIZE_D, 1'b0, 64'h10, '0, 1'b0, 64'h8899AABBCCDDEEFF, 3, 1'b0);
    finish_ops("ld_before_mis");
    model_rdata = 64'h8899AABBCCDDEEFF;
    en0 = n_en;
    issue("lw_0x22", 1'b0, SIZE_W, 1'b0, 64'h22, '0, 1'b1, model_rdata, 1, 1'b0);
    issue("sh_0x21", 1'b1, SIZE_H, 1'b0, 64'h21, 64'hFFFF, 1'b1, model_rdata, 1, 1'b0);
    issue("ld_0x24", 1'b0, SIZE_D, 1'b0, 64'h24, '0, 1'b1, model_rdata, 1, 1'b0);
    issue("sw_0x26", 1'b1, SIZE_W, 1'b0, 64'h26, 64'h55, 1'b1, model_rdata, 1, 1'b0);
    finish_ops("misalign");
    n_chk++; if (n_en !== en0) begin n_fail++; $display("FAIL misalign_mem_en count=%0d required %0d", n_en, en0); end
    n_chk++; if (ram[4] !== 64'd0) begin n_fail++; $display("FAIL misalign_ram4 ram=%h required 0", ram[4]); end
    issue("lh_0x22", 1'b0, SIZE_H, 1'b1, 64'h22, '0, 1'b0, 64'd0, 3, 1'b0);
    finish_ops("lh_aligned");
    model_rdata = '0;
  endtask

  task automatic test_back_to_back();
    issue("b2b_sd", 1'b1, SIZE_D, 1'b0, 64'h30, 64'h0123456789ABCDEF, 1'b0, model_rdata, 2, 1'b1);
    issue("b2b_ld", 1'b0, SIZE_D, 1'b0, 64'h30, '0, 1'b0, 64'h0123456789ABCDEF, 3, 1'b1);
    issue("b2b_sb", 1'b1, SIZE_B, 1'b0, 64'h33, 64'h5A, 1'b0, 64'h0123456789ABCDEF, 4, 1'b1);
    issue("b2b_lbu", 1'b0, SIZE_B, 1'b0, 64'h33, '0, 1'b0, 64'h000000000000005A, 3, 1'b1);
    issue("b2b_ld2", 1'b0, SIZE_D, 1'b0, 64'h30, '0, 1'b0, 64'h0123455A89ABCDEF, 3, 1'b0);
    finish_ops("back_to_back");
    n_chk++; if (ram[6] !== 64'h0123455A89ABCDEF) begin n_fail++; $display("FAIL b2b_ram6 ram=%h required %h", ram[6], 64'h0123455A89ABCDEF); end
  endtask

  initial begin
    for (int i = 0; i < int'(RAM_WORDS); i++) ram[i] = '0;
    ram[1] = 64'h1111111111111111;
    ram[2] = 64'h8899AABBCCDDEEFF;
    test_reset();
    test_loads();
    test_substores();
    test_abort();
    test_misalign();
    test_back_to_back();
    n_chk++;
    if (n_oob !== 0) begin
      n_fail++;
      $display("FAIL ram_addr_range out_of_range=%0d required 0", n_oob);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
